mouse_pos_tracker: RTL and testbench

- Receives raw PS/2 mouse traffic and assembles standard 3-byte movement packets.
- Accumulates the signed X/Y deltas into a clamped on-screen cursor position, plus left/right button state.
- Sits directly upstream of the cursor-drawing stage; pos_x/pos_y feed that stage's position comparison against the VGA pixel counters.
- Single clock domain; the PS/2 lines are asynchronous and synchronized internally.

---
 rtl/mouse_pos_tracker.sv | 120 ++++++++++++
 tb/tb_mouse_pos_tracker.sv | 126 ++++++++++++
 2 files changed

// File: rtl/mouse_pos_tracker.sv
// mouse_pos_tracker: decodes PS/2 mouse packets into a clamped cursor position and button state.
module mouse_pos_tracker #(
    parameter int H_MAX   = 639,
    parameter int V_MAX   = 479,
    parameter int X_INIT  = 320,
    parameter int Y_INIT  = 240,
    parameter int TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       btn_l,
    output logic       btn_r,
    output logic       pkt_valid,
    output logic       frame_err
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    localparam int TW = $clog2(TIMEOUT + 1);
    state_t state, state_n;
    logic [1:0] clk_s, data_s;
    logic [3:0] hist;
    logic filt, sample, din, good, active, tmo, par;
    logic [2:0] bit_cnt;
    logic [7:0] shreg, b1;
    logic [5:0] hdr;
    logic [1:0] idx;
    logic [TW-1:0] cnt;
    logic [10:0] x_sum, y_sum;
    logic [9:0] x_new, y_new;
    assign din    = data_s[1];
    // falling edge of the filtered clock: filter still high, last four samples low
    assign sample = filt && hist == 4'b0000;
    assign good   = din && ^{shreg, par};
    assign active = state != IDLE || idx != 2'd0;
    assign tmo    = active && !sample && cnt == TW'(TIMEOUT - 1);
    // hdr = {y_ovf, x_ovf, y_sign, x_sign, btn_r, btn_l}; dy comes straight from the shifter
    assign x_sum  = {1'b0, pos_x} + {{3{hdr[2]}}, b1};
    assign y_sum  = {1'b0, pos_y} - {{3{hdr[3]}}, shreg};
    assign x_new  = hdr[4] ? pos_x : x_sum[10] ? 10'd0 : x_sum[9:0] > 10'(H_MAX) ? 10'(H_MAX) : x_sum[9:0];
    assign y_new  = hdr[5] ? pos_y : y_sum[10] ? 10'd0 : y_sum[9:0] > 10'(V_MAX) ? 10'(V_MAX) : y_sum[9:0];
    always_comb begin
        state_n = state;
        if (tmo)
            state_n = IDLE;
        else if (sample)
            case (state)
                IDLE:    state_n = din ? IDLE : DATA;
                DATA:    state_n = bit_cnt == 3'd7 ? PARITY : DATA;
                PARITY:  state_n = STOP;
                default: state_n = IDLE;
            endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s     <= 2'b11;
            data_s    <= 2'b11;
            hist      <= 4'hF;
            filt      <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            hdr       <= '0;
            b1        <= '0;
            idx       <= '0;
            cnt       <= '0;
            pos_x     <= 10'(X_INIT);
            pos_y     <= 10'(Y_INIT);
            btn_l     <= 1'b0;
            btn_r     <= 1'b0;
            pkt_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_s     <= {clk_s[0], ps2_clk};
            data_s    <= {data_s[0], ps2_data};
            hist      <= {hist[2:0], clk_s[1]};
            filt      <= hist == 4'hF ? 1'b1 : hist == 4'h0 ? 1'b0 : filt;
            state     <= state_n;
            cnt       <= (sample || !active || tmo) ? '0 : cnt + 1'b1;
            pkt_valid <= 1'b0;
            frame_err <= tmo;
            if (tmo)
                idx <= '0;
            if (sample) begin
                if (state == IDLE)
                    bit_cnt <= '0;
                if (state == DATA) begin
                    shreg   <= {din, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == PARITY)
                    par <= din;
                if (state == STOP) begin
                    if (!good) begin
                        frame_err <= 1'b1;
                        idx       <= '0;
                    end else if (idx == 2'd0) begin
                        if (shreg[3]) begin
                            hdr <= {shreg[7:4], shreg[1:0]};
                            idx <= 2'd1;
                        end
                    end else if (idx == 2'd1) begin
                        b1  <= shreg;
                        idx <= 2'd2;
                    end else begin
                        idx       <= '0;
                        pos_x     <= x_new;
                        pos_y     <= y_new;
                        btn_l     <= hdr[0];
                        btn_r     <= hdr[1];
                        pkt_valid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mouse_pos_tracker.sv
// tb_mouse_pos_tracker: directed PS/2 packet sequences against hand-computed cursor results.
module tb_mouse_pos_tracker;
    logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [9:0] pos_x, pos_y;
    logic btn_l, btn_r, pkt_valid, frame_err;
    int checks = 0, errors = 0, pv = 0, fe = 0, pv0, fe0;

    mouse_pos_tracker #(.TIMEOUT(500)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .pos_x(pos_x), .pos_y(pos_y), .btn_l(btn_l), .btn_r(btn_r),
        .pkt_valid(pkt_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (pkt_valid) pv++;
        if (frame_err) fe++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        #100 ps2_clk = 1'b0;
        #200 ps2_clk = 1'b1;
        #100;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad = 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ bad);
        send_bit(1'b1);
        #200;
    endtask

    task automatic send_pkt(input logic [7:0] b0, b1, b2);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
    endtask

    task automatic chk_pos(input string tag, input int x, y);
        chk({tag, "_x"}, 32'(pos_x), 32'(x));
        chk({tag, "_y"}, 32'(pos_y), 32'(y));
    endtask

    initial begin
        #52 reset = 1'b0;
        #100;
        chk_pos("reset", 320, 240);
        chk("reset_btn_l", 32'(btn_l), 0);
        chk("reset_btn_r", 32'(btn_r), 0);
        chk("reset_pkt_valid", 32'(pkt_valid), 0);
        chk("reset_frame_err", 32'(frame_err), 0);

        pv0 = pv;
        send_pkt(8'h09, 8'h0A, 8'h05);
        chk("p1_pulses", 32'(pv - pv0), 1);
        chk_pos("p1", 330, 235);
        chk("p1_btn_l", 32'(btn_l), 1);
        chk("p1_btn_r", 32'(btn_r), 0);

        send_pkt(8'h38, 8'h9C, 8'hF6);
        chk_pos("p2", 230, 245);
        chk("p2_btn_l", 32'(btn_l), 0);

        send_pkt(8'h38, 8'h2E, 8'h1F);
        chk_pos("p3", 20, 470);
        send_pkt(8'h18, 8'h9C, 8'h00);
        chk_pos("clamp_x0", 0, 470);
        send_pkt(8'h28, 8'h00, 8'hE2);
        chk_pos("clamp_ymax", 0, 479);

        pv0 = pv; fe0 = fe;
        send_byte(8'h08);
        send_byte(8'h05, 1'b1);
        chk("par_err_pulse", 32'(fe - fe0), 1);
        chk("par_err_no_pkt", 32'(pv - pv0), 0);
        chk_pos("par_err", 0, 479);
        send_pkt(8'h08, 8'h05, 8'h00);
        chk_pos("after_err", 5, 479);

        send_pkt(8'h48, 8'h10, 8'h05);
        chk_pos("x_ovf", 5, 474);

        pv0 = pv; fe0 = fe;
        send_byte(8'h02);
        send_pkt(8'h08, 8'h01, 8'h00);
        chk("resync_no_err", 32'(fe - fe0), 0);
        chk("resync_pulses", 32'(pv - pv0), 1);
        chk_pos("resync", 6, 474);

        fe0 = fe; pv0 = pv;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #7000;
        chk("timeout_pulse", 32'(fe - fe0), 1);
        chk("timeout_no_pkt", 32'(pv - pv0), 0);
        send_pkt(8'h09, 8'h00, 8'h01);
        chk_pos("after_tmo", 6, 473);
        chk("after_tmo_btn_l", 32'(btn_l), 1);

        send_byte(8'h08);
        send_byte(8'h10);
        #33 reset = 1'b1;
        #1;
        chk_pos("midreset", 320, 240);
        chk("midreset_btn_l", 32'(btn_l), 0);
        #66 reset = 1'b0;
        #100;
        send_pkt(8'h0A, 8'h02, 8'h00);
        chk_pos("post_reset", 322, 240);
        chk("post_reset_btn_r", 32'(btn_r), 1);
        chk("post_reset_btn_l", 32'(btn_l), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
